multicycle_controller: RTL and testbench

Multi-cycle RISC-V control unit: a state machine that sequences fetch, decode, execute, memory and writeback over several clock cycles. It drives the shared-memory datapath of the multi-cycle CPU. It is the parametrised successor of the single-cycle `controller`, and it adds two things that block does not have: a memory-ready handshake and an optional `bne` branch mode. It also adds an illegal-opcode halt. The ALU decode (`ALU_control`) matches the single-cycle unit exactly.

---
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/
// writeback for the shared-memory datapath, with a memory-ready handshake,
// optional bne support and an illegal-opcode halt.
module multicycle_controller #(
  parameter bit BNE_ENABLE      = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       adr_select,
  output logic       mem_write,
  output logic       mem_request,
  output logic       IR_write,
  output logic [1:0] result_select,
  output logic [1:0] ALU_select_A,
  output logic [1:0] ALU_select_B,
  output logic [1:0] imm_select,
  output logic       reg_write,
  output logic [2:0] ALU_control,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;
  logic   [2:0] funct_alu;
  logic   br_taken;

  // funct3/funct7 decode used by the R and I execute states
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // branch resolution; unsupported funct3 values never redirect the PC
  always_comb begin
    br_taken = ((funct3 == 3'b000) & zero) |
               (BNE_ENABLE & (funct3 == 3'b001) & ~zero);
  end

  // next-state logic; mem_ready only matters in the three memory states
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = (state_q == S_JAL) ? S_ALUWB : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // state register; reset aborts whatever instruction is in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // output decode of the current state; kept combinational so the
  // mem_ready/zero qualification acts in the same cycle
  always_comb begin
    PC_write      = 1'b0;
    adr_select    = 1'b0;
    mem_write     = 1'b0;
    mem_request   = 1'b0;
    IR_write      = 1'b0;
    result_select = 2'b00;
    ALU_select_A  = 2'b00;
    ALU_select_B  = 2'b00;
    reg_write     = 1'b0;
    ALU_control   = ALU_ADD;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_request   = 1'b1;
        ALU_select_B  = 2'b10;
        result_select = 2'b10;
        IR_write      = mem_ready;
        PC_write      = mem_ready;
      end
      S_DECODE: begin
        ALU_select_A = 2'b01;
        ALU_select_B = 2'b01;
      end
      S_MEMADR: begin
        ALU_select_A = 2'b10;
        ALU_select_B = 2'b01;
      end
      S_MEMREAD: begin
        mem_request = 1'b1;
        adr_select  = 1'b1;
      end
      S_MEMWB: begin
        result_select = 2'b01;
        reg_write     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_request = 1'b1;
        adr_select  = 1'b1;
        mem_write   = 1'b1;
      end
      S_EXECR: begin
        ALU_select_A = 2'b10;
        ALU_control  = funct_alu;
      end
      S_EXECI: begin
        ALU_select_A = 2'b10;
        ALU_select_B = 2'b01;
        ALU_control  = funct_alu;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_JAL: begin
        ALU_select_A = 2'b01;
        ALU_select_B = 2'b10;
        PC_write     = 1'b1;
      end
      S_BRANCH: begin
        ALU_select_A = 2'b10;
        ALU_control  = ALU_SUB;
        PC_write     = br_taken;
      end
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PC_write    = 1'b0;
      IR_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      mem_request = 1'b0;
    end
  end

  // immediate format follows the opcode regardless of state
  always_comb begin
    case (opcode)
      OP_SW:   imm_select = 2'b01;
      OP_BR:   imm_select = 2'b10;
      OP_JAL:  imm_select = 2'b11;
      default: imm_select = 2'b00;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (default parameters and
// BNE_ENABLE=0/HALT_ON_ILLEGAL=0) share stimulus; random instruction streams
// are expanded into expected per-cycle state traces and control words.
module tb_multicycle_controller;

  typedef struct packed {
    logic       hlt, pcw, irw, rw, mw, mreq, adr;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
  } ctl_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clock = 1'b0;
  logic reset, funct7b5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic pcw [2], adr [2], mw [2], mreq [2], irw [2], rw [2], hlt [2];
  logic [1:0] rs [2], sa [2], sb [2], imm [2];
  logic [2:0] aluc [2];
  logic [3:0] st [2];
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  multicycle_controller u0 (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .PC_write(pcw[0]), .adr_select(adr[0]), .mem_write(mw[0]),
    .mem_request(mreq[0]), .IR_write(irw[0]), .result_select(rs[0]),
    .ALU_select_A(sa[0]), .ALU_select_B(sb[0]), .imm_select(imm[0]),
    .reg_write(rw[0]), .ALU_control(aluc[0]), .halted(hlt[0]), .state(st[0]));

  multicycle_controller #(.BNE_ENABLE(1'b0), .HALT_ON_ILLEGAL(1'b0)) u1 (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .PC_write(pcw[1]), .adr_select(adr[1]), .mem_write(mw[1]),
    .mem_request(mreq[1]), .IR_write(irw[1]), .result_select(rs[1]),
    .ALU_select_A(sa[1]), .ALU_select_B(sb[1]), .imm_select(imm[1]),
    .reg_write(rw[1]), .ALU_control(aluc[1]), .halted(hlt[1]), .state(st[1]));

  task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // ALU operation the R/I execute stages should request
  function automatic logic [2:0] exec_alu();
    if (funct3 == 3'd0) return (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
    if (funct3 == 3'd2) return 3'b101;
    if (funct3 == 3'd6) return 3'b011;
    if (funct3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  // expected control word for instance d sitting in state s
  function automatic ctl_t expect_ctl(int d, int s, logic mr, logic z, logic rst);
    ctl_t c = '0;
    c.imm = (opcode == SW) ? 2'b01 : (opcode == BR) ? 2'b10 :
            (opcode == JL) ? 2'b11 : 2'b00;
    case (s)
      0:  begin c.mreq = 1; c.sb = 2; c.rs = 2; c.irw = mr; c.pcw = mr; end
      1:  begin c.sa = 1; c.sb = 1; end
      2:  begin c.sa = 2; c.sb = 1; end
      3:  begin c.mreq = 1; c.adr = 1; end
      4:  begin c.rs = 1; c.rw = 1; end
      5:  begin c.mreq = 1; c.adr = 1; c.mw = 1; end
      6:  begin c.sa = 2; c.alu = exec_alu(); end
      7:  c.rw = 1;
      8:  begin c.sa = 2; c.sb = 1; c.alu = exec_alu(); end
      9:  begin c.sa = 1; c.sb = 2; c.pcw = 1; end
      10: begin
        c.sa = 2; c.alu = 3'b001;
        c.pcw = (funct3 == 3'd0 && z) || (d == 0 && funct3 == 3'd1 && !z);
      end
      11: c.hlt = 1;
      default: ;
    endcase
    if (rst) begin c.pcw = 0; c.irw = 0; c.mw = 0; c.rw = 0; c.mreq = 0; end
    return c;
  endfunction

  // one clock cycle: drive inputs after negedge, check, advance
  task automatic step(int s0, int s1, logic mr, logic rst);
    int es [2];
    es[0] = s0; es[1] = s1;
    mem_ready = mr; reset = rst; zero = 1'($urandom_range(1));
    #1;
    for (int d = 0; d < 2; d++) begin
      ctl_t o, e;
      o = '{hlt[d], pcw[d], irw[d], rw[d], mw[d], mreq[d], adr[d],
            rs[d], sa[d], sb[d], aluc[d], imm[d]};
      e = expect_ctl(d, es[d], mr, zero, rst);
      check("state", d, 32'(st[d]), 32'(es[d]));
      check($sformatf("ctl@s%0d", es[d]), d, 32'(o), 32'(e));
    end
    @(negedge clock);
  endtask

  // run one legal instruction through both instances with memory stalls
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f7, int fw, int mwt);
    int sq [$];
    logic mq [$];
    opcode = op; funct3 = f3; funct7b5 = f7;
    repeat (fw) begin sq.push_back(0); mq.push_back(0); end
    sq.push_back(0); mq.push_back(1);
    sq.push_back(1); mq.push_back(1'($urandom_range(1)));
    case (op)
      LW: begin
        sq.push_back(2); mq.push_back(1'($urandom_range(1)));
        repeat (mwt) begin sq.push_back(3); mq.push_back(0); end
        sq.push_back(3); mq.push_back(1);
        sq.push_back(4); mq.push_back(1'($urandom_range(1)));
      end
      SW: begin
        sq.push_back(2); mq.push_back(1'($urandom_range(1)));
        repeat (mwt) begin sq.push_back(5); mq.push_back(0); end
        sq.push_back(5); mq.push_back(1);
      end
      RT: begin sq.push_back(6); mq.push_back(1'($urandom_range(1)));
                sq.push_back(7); mq.push_back(1'($urandom_range(1))); end
      IT: begin sq.push_back(8); mq.push_back(1'($urandom_range(1)));
                sq.push_back(7); mq.push_back(1'($urandom_range(1))); end
      JL: begin sq.push_back(9); mq.push_back(1'($urandom_range(1)));
                sq.push_back(7); mq.push_back(1'($urandom_range(1))); end
      default: begin sq.push_back(10); mq.push_back(1'($urandom_range(1))); end
    endcase
    foreach (sq[i]) step(sq[i], sq[i], mq[i], 1'b0);
  endtask

  initial begin
    logic [6:0] ops [6];
    ops = '{LW, SW, RT, IT, JL, BR};
    reset = 1; mem_ready = 1; zero = 0; opcode = RT; funct3 = 0; funct7b5 = 0;
    @(negedge clock);
    // reset cycle: FETCH decode with enables forced low
    step(0, 0, 1'b1, 1'b1);

    // directed instructions from the plan
    run_instr(RT, 3'd0, 1'b0, 0, 0);   // add
    run_instr(LW, 3'd2, 1'b0, 0, 2);   // lw, two stall cycles
    run_instr(RT, 3'd0, 1'b1, 0, 0);   // sub
    run_instr(RT, 3'd2, 1'b0, 1, 0);   // slt
    run_instr(IT, 3'd0, 1'b1, 0, 0);   // addi ignores funct7b5
    run_instr(BR, 3'd0, 1'b0, 0, 0);   // beq
    run_instr(BR, 3'd1, 1'b0, 0, 0);   // bne
    run_instr(SW, 3'd2, 1'b0, 2, 3);   // sw with stalls
    run_instr(JL, 3'd0, 1'b0, 0, 0);   // jal

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = ops[$urandom_range(5)];
      f3 = 3'($urandom_range(7));
      if (op == BR && $urandom_range(1) == 0) f3 = 3'($urandom_range(1));
      run_instr(op, f3, 1'($urandom_range(1)), $urandom_range(2), $urandom_range(3));
    end

    // illegal opcode: u0 halts, u1 skips back to FETCH
    opcode = BAD; funct3 = 0;
    step(0, 0, 1'b1, 1'b0);
    step(1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(11, (i % 2 == 0) ? 0 : 1, 1'b1, 1'b0);
    step(11, 0, 1'b1, 1'b1);           // reset while halted
    step(0, 0, 1'b0, 1'b0);

    // sw aborted by reset in the middle of MEMWRITE
    opcode = SW; funct3 = 3'd2;
    step(0, 0, 1'b1, 1'b0);
    step(1, 1, 1'b1, 1'b0);
    step(2, 2, 1'b1, 1'b0);
    step(5, 5, 1'b0, 1'b0);
    step(5, 5, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    step(1, 1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
